// File: rtl/echo_pkg.sv
// Shared types for the echo queue: message kinds, output-stage states
// and widths used by both the queue storage and the output stage.
package echo_pkg;

  localparam int KIND_W  = 2;
  localparam int TIMER_W = 4;

  typedef enum logic [KIND_W-1:0] {
    KIND_NONE = 2'd0,
    SAY       = 2'd1,
    SAY2      = 2'd2
  } kind_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_OFFER = 2'd2
  } state_t;

endpackage

// File: rtl/echo_fifo.sv
// Circular message store: power-of-two depth, wrapping pointers,
// separate occupancy counter for full/empty.
module echo_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = level == CW'(DEPTH);
  assign empty   = level == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/echo_queue.sv
// Echo queue: accepts say/say2 requests, holds them in order, and replays
// each as a heard/heard2 indication after a programmable wait.
module echo_queue
  import echo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int DELAY = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       request_say__ENA,
  input  logic [WIDTH-1:0]           request_say_v,
  output logic                       request_say__RDY,
  input  logic                       request_say2__ENA,
  input  logic [WIDTH/2-1:0]         request_say2_a,
  input  logic [WIDTH/2-1:0]         request_say2_b,
  output logic                       request_say2__RDY,
  input  logic                       request_setLeds__ENA,
  input  logic [7:0]                 request_setLeds_v,
  output logic                       request_setLeds__RDY,
  output logic                       indication_heard__ENA,
  output logic [WIDTH-1:0]           indication_heard_v,
  input  logic                       indication_heard__RDY,
  output logic                       indication_heard2__ENA,
  output logic [WIDTH/2-1:0]         indication_heard2_a,
  output logic [WIDTH/2-1:0]         indication_heard2_b,
  input  logic                       indication_heard2__RDY,
  output logic [7:0]                 leds,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);

  localparam int HW = WIDTH / 2;
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = WIDTH + KIND_W;

  typedef struct packed {
    kind_t            kind;
    logic [WIDTH-1:0] payload;
  } entry_t;

  state_t             state;
  state_t             state_n;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_n;
  entry_t             stage;
  entry_t             stage_n;
  entry_t             wdata;
  entry_t             head;
  logic [EW-1:0]      head_bits;
  logic               full;
  logic               empty;
  logic [CW-1:0]      level;
  logic               push;
  logic               pop;
  logic               load;
  logic               done;
  logic               any_ena;
  logic               err_set;
  logic               say_out;
  logic               say2_out;

  assign any_ena = request_say__ENA || request_say2__ENA;
  assign push    = any_ena && !full;
  assign err_set = (request_say__ENA && request_say2__ENA)
                || (any_ena && full);

  assign request_say__RDY     = !full;
  assign request_say2__RDY    = !full;
  assign request_setLeds__RDY = 1'b1;

  // say wins when both arrive together; say2 is dropped and flagged
  always_comb begin
    wdata.kind    = request_say__ENA ? SAY : SAY2;
    wdata.payload = request_say__ENA ? request_say_v
                                     : {request_say2_a, request_say2_b};
  end

  echo_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head_bits),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign head = entry_t'(head_bits);

  assign say_out  = (state == S_OFFER) && (stage.kind == SAY);
  assign say2_out = (state == S_OFFER) && (stage.kind == SAY2);
  assign done     = (say_out && indication_heard__RDY)
                 || (say2_out && indication_heard2__RDY);

  assign indication_heard__ENA  = say_out && indication_heard__RDY;
  assign indication_heard2__ENA = say2_out && indication_heard2__RDY;
  assign indication_heard_v  = say_out ? stage.payload : '0;
  assign indication_heard2_a = say2_out ? stage.payload[WIDTH-1:HW] : '0;
  assign indication_heard2_b = say2_out ? stage.payload[HW-1:0] : '0;

  assign count = level + CW'(state != S_EMPTY);

  always_comb begin
    state_n = state;
    timer_n = timer;
    stage_n = stage;
    load    = 1'b0;
    case (state)
      S_EMPTY: load = !empty;
      S_WAIT: begin
        timer_n = timer - 1'b1;
        if (timer <= TIMER_W'(1)) state_n = S_OFFER;
      end
      S_OFFER: begin
        if (done) begin
          if (!empty) load = 1'b1;
          else        state_n = S_EMPTY;
        end
      end
      default: state_n = S_EMPTY;
    endcase
    // a completed offer refills from the head in the same cycle
    if (load) begin
      stage_n = head;
      if (DELAY == 0) begin
        state_n = S_OFFER;
      end else begin
        state_n = S_WAIT;
        timer_n = TIMER_W'(DELAY);
      end
    end
  end

  assign pop = load;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_EMPTY;
      timer <= '0;
      stage <= '0;
      leds  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      stage <= stage_n;
      if (request_setLeds__ENA) leds <= request_setLeds_v;
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_echo_queue.sv
// Bench for echo_queue: vector table plus scoreboard-checked output,
// with hand-built sequences for backpressure, collisions and reset.
module tb_echo_queue;

  localparam int W  = 32;
  localparam int HW = 16;
  localparam int D  = 4;
  localparam int DL = 1;
  localparam int CW = $clog2(D+1);

  logic          clk;
  logic          rst;
  logic          say_ena;
  logic [W-1:0]  say_v;
  logic          say_rdy;
  logic          say2_ena;
  logic [HW-1:0] say2_a;
  logic [HW-1:0] say2_b;
  logic          say2_rdy;
  logic          leds_ena;
  logic [7:0]    leds_v;
  logic          leds_rdy;
  logic          h_ena;
  logic [W-1:0]  h_v;
  logic          h_rdy;
  logic          h2_ena;
  logic [HW-1:0] h2_a;
  logic [HW-1:0] h2_b;
  logic          h2_rdy;
  logic [7:0]    leds;
  logic [CW-1:0] count;
  logic          err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic         is2;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    bit            is2;
    logic [W-1:0]  v;
    logic [HW-1:0] a;
    logic [HW-1:0] b;
    exp_t          exp;
  } vec_t;

  vec_t vecs[6];

  echo_queue #(
    .WIDTH (W),
    .DEPTH (D),
    .DELAY (DL)
  ) dut (
    .CLK                    (clk),
    .RST                    (rst),
    .request_say__ENA       (say_ena),
    .request_say_v          (say_v),
    .request_say__RDY       (say_rdy),
    .request_say2__ENA      (say2_ena),
    .request_say2_a         (say2_a),
    .request_say2_b         (say2_b),
    .request_say2__RDY      (say2_rdy),
    .request_setLeds__ENA   (leds_ena),
    .request_setLeds_v      (leds_v),
    .request_setLeds__RDY   (leds_rdy),
    .indication_heard__ENA  (h_ena),
    .indication_heard_v     (h_v),
    .indication_heard__RDY  (h_rdy),
    .indication_heard2__ENA (h2_ena),
    .indication_heard2_a    (h2_a),
    .indication_heard2_b    (h2_b),
    .indication_heard2__RDY (h2_rdy),
    .leds                   (leds),
    .count                  (count),
    .err                    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (sb.size() == 0 && count == '0) ok = 1'b1;
    end
    check(name, {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_rdy();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (say_rdy && say2_rdy) ok = 1'b1;
      else tick();
    end
    check("wait_rdy", {63'd0, ok}, 64'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (h_ena && h2_ena) begin
        checks++;
        errors++;
        $display("FAIL both_ena: got 1,1 want one of them");
      end else if (h_ena || h2_ena) begin
        exp_t got;
        got.is2  = h2_ena;
        got.data = h2_ena ? {h2_a, h2_b} : h_v;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h want none", got);
        end else begin
          check("out_order", 64'(got), 64'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    int lat;
    vecs[0] = '{0, 32'h0000000A, 16'h0, 16'h0, '{1'b0, 32'h0000000A}};
    vecs[1] = '{1, 32'h0, 16'h0001, 16'h0002, '{1'b1, 32'h00010002}};
    vecs[2] = '{0, 32'h0000000B, 16'h0, 16'h0, '{1'b0, 32'h0000000B}};
    vecs[3] = '{0, 32'hFFFFFFFF, 16'h0, 16'h0, '{1'b0, 32'hFFFFFFFF}};
    vecs[4] = '{1, 32'h0, 16'hFFFF, 16'h0000, '{1'b1, 32'hFFFF0000}};
    vecs[5] = '{1, 32'h0, 16'h8001, 16'h7FFE, '{1'b1, 32'h80017FFE}};

    rst = 1'b1;
    say_ena = 0; say_v = '0;
    say2_ena = 0; say2_a = '0; say2_b = '0;
    leds_ena = 0; leds_v = '0;
    h_rdy = 1; h2_rdy = 1;
    tick();
    tick();
    check("rst_count", count, 0);
    check("rst_err", err, 0);
    check("rst_leds", leds, 0);
    check("rst_h_ena", {h_ena, h2_ena}, 0);
    check("rst_h_data", {h_v, h2_a, h2_b}, 0);
    check("rst_ledrdy", leds_rdy, 1);
    rst = 1'b0;
    tick();
    check("rdy_after_rst", {say_rdy, say2_rdy}, 2'b11);

    // single say: latency and one-cycle pulse
    say_ena = 1; say_v = 32'h12345678;
    sb.push_back('{1'b0, 32'h12345678});
    tick();
    say_ena = 0;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      tick();
      if (h_ena) lat = k + 1;
    end
    check("latency", lat, DL + 2);
    tick();
    check("one_cycle", h_ena, 0);
    drain("drain_single");

    // table of back-to-back messages, consumer always ready
    foreach (vecs[i]) begin
      wait_rdy();
      say_ena  = !vecs[i].is2;
      say2_ena = vecs[i].is2;
      say_v    = vecs[i].v;
      say2_a   = vecs[i].a;
      say2_b   = vecs[i].b;
      sb.push_back(vecs[i].exp);
      tick();
    end
    say_ena = 0; say2_ena = 0;
    drain("drain_table");
    check("table_err", err, 0);

    // fill queue and stage under backpressure
    h_rdy = 0; h2_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      say_ena = 1; say_v = 32'h100 + i;
      sb.push_back('{1'b0, 32'h100 + i});
      tick();
    end
    say_ena = 0;
    check("full_count", count, 5);
    check("full_rdy", {say_rdy, say2_rdy}, 0);
    check("full_err0", err, 0);
    say_ena = 1; say_v = 32'hDEAD;
    tick();
    say_ena = 0;
    check("overflow_err", err, 1);
    check("overflow_count", count, 5);
    leds_ena = 1; leds_v = 8'h5A;
    tick();
    leds_ena = 0;
    check("leds_load", leds, 8'h5A);
    check("leds_count", count, 5);
    h_rdy = 1; h2_rdy = 1;
    drain("drain_full");
    check("err_sticky", err, 1);
    pulse_reset();
    check("err_clear", err, 0);
    check("leds_clear", leds, 0);

    // say and say2 together: say kept, say2 dropped
    say_ena = 1; say_v = 32'h111;
    say2_ena = 1; say2_a = 16'h3; say2_b = 16'h4;
    sb.push_back('{1'b0, 32'h111});
    tick();
    say_ena = 0; say2_ena = 0;
    check("collide_err", err, 1);
    drain("drain_collide");
    check("collide_sticky", err, 1);
    pulse_reset();

    // reset with three queued and one offered
    h_rdy = 0; h2_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      say_ena = 1; say_v = 32'h200 + i;
      sb.push_back('{1'b0, 32'h200 + i});
      tick();
    end
    say_ena = 0;
    check("pre_rst_count", count, 4);
    check("pre_rst_offer", h_v, 32'h200);
    rst = 1'b1;
    tick();
    check("mid_rst_count", count, 0);
    check("mid_rst_ena", {h_ena, h2_ena}, 0);
    check("mid_rst_data", h_v, 0);
    sb.delete();
    rst = 1'b0;
    h_rdy = 1; h2_rdy = 1;
    tick();
    check("post_rst_rdy", {say_rdy, say2_rdy}, 2'b11);
    repeat (8) tick();
    check("post_rst_count", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
